muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle unsigned MUL/DIVU/REMU unit built on the shared 32-bit ALU, with no multiplier or divider of its own.
//  It sequences shift-add multiply and restoring divide by driving ALU ops ADD(0000), SUB(0001) and SLTU(0011).
//  The parent muxes the ALU inputs to this block while busy=1; the execute stage owns the ALU otherwise.
// PARAMETERS
//  WIDTH    32               operand/ALU width; must equal the ALU width
//  CNT_W    $clog2(WIDTH)+1  iteration counter width (localparam)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid&&in_ready
//  func       in   2      00 MUL(low) 01 reserved 10 DIVU 11 REMU
//  op_a       in   WIDTH  multiplicand / dividend
//  op_b       in   WIDTH  multiplier / divisor
//  res_valid  out  1      result valid
//  res_ready  in   1      result consumed when res_valid&&res_ready
//  result     out  WIDTH  product low / quotient / remainder
//  busy       out  1      high outside IDLE; parent routes alu_* to ALU
//  alu_a      out  WIDTH  ALU operand A
//  alu_b      out  WIDTH  ALU operand B
//  alu_op     out  4      ALU opcode
//  alu_result in   WIDTH  ALU result (combinational, same cycle)
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; res_valid=0; result=0; busy=0; alu_a=alu_b=0; alu_op=0000.
//  - States: IDLE, MUL, DIV_CMP, DIV_SUB, DONE.
//    - IDLE: in_ready=1. On accept in cycle T, latch operands/func and set cnt=0.
//    - From IDLE: MUL -> MUL; DIVU/REMU with op_b==0 -> DONE; DIVU/REMU otherwise -> DIV_CMP; reserved -> DONE with result=0.
//  - MUL: acc starts at 0; mcand=op_a; mplier=op_b. Each cycle: alu_op=ADD, alu_a=acc, alu_b = mplier[0] ? mcand : 0.
//    - Each cycle also: acc<=alu_result; mcand<<=1; mplier>>=1; cnt++.
//    - After 32 cycles go to DONE; product is mod 2^32; res_valid at T+33.
//  - DIV (restoring): R=0, Q=op_a, D=op_b.
//    - DIV_CMP: {ovf,Rs}={R,Q[31]}; Q<<=1. Drive alu_op=SLTU, alu_a=Rs, alu_b=D.
//      - ge = ovf | ~alu_result[0]; register Rs and ge.
//    - DIV_SUB: alu_op=SUB, alu_a=Rs, alu_b=D.
//      - If ge: R<=alu_result and Q[0]<=1; else R<=Rs. cnt++.
//      - The 32-bit wrap on the ovf case yields the correct remainder.
//    - Fixed 2 cycles per bit, 32 bits; res_valid at T+65. DIVU returns Q, REMU returns R.
//  - Divide by zero: DIVU gives 0xFFFFFFFF, REMU gives op_a; res_valid at T+1; ALU not driven.
//  - DONE: res_valid=1; result stable until res_ready. Then -> IDLE (in_ready=1 next cycle).
//    - No accept is possible in the DONE cycle; minimum issue interval is latency+1.
//  - in_ready=0 and busy=1 in every state except IDLE; in_valid is ignored while not IDLE.
//  - ALU outputs are idle values (0,0,0000) in IDLE/DONE; they are defined and stable in each active cycle.
//  - rst_n low in any state aborts the operation: next cycle is IDLE, res_valid=0, and no partial result is ever presented.
//  - cnt saturates at 32; the FSM never re-enters MUL/DIV states without a new accept.
// STRUCTURE
//  - alu_pkg (shared with the ALU): ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_SLTU=4'b0011;
//    FUNC_MUL/FUNC_RSV/FUNC_DIVU/FUNC_REMU; muldiv state encoding.
//  - No sub-module: FSM plus acc/R, Q/mplier, mcand/D and cnt registers in one module.
//  - The ALU is instantiated in the parent, not here.
// TESTING
//  1. MUL 7*6: accept at T -> busy T+1..T+32; res_valid=1 at T+33, result=42.
//  2. MUL 0xFFFFFFFF*2 -> 0xFFFFFFFE (wrap). MUL 0x12345678*0 -> 0.
//  3. DIVU 100/7 -> 14 at T+65; REMU 100/7 -> 2 at T+65.
//  4. DIVU 0xFFFFFFFF/0x80000001 (ovf path) -> q=1; REMU -> 0x7FFFFFFE.
//  5. DIVU 5/0 -> 0xFFFFFFFF at T+1; REMU 5/0 -> 5 at T+1; alu_op stays 0000.
//  6. rst_n low at MUL cycle 10 -> next cycle IDLE, in_ready=1, res_valid=0.
//     res_ready held low 5 cycles in DONE -> result and res_valid held, in_ready=0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, mul/div function codes and the
// muldiv sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0011;

    localparam logic [1:0] FUNC_MUL  = 2'b00;
    localparam logic [1:0] FUNC_RSV  = 2'b01;
    localparam logic [1:0] FUNC_DIVU = 2'b10;
    localparam logic [1:0] FUNC_REMU = 2'b11;

    typedef enum logic [2:0] {
        MD_IDLE    = 3'd0,
        MD_MUL     = 3'd1,
        MD_DIV_CMP = 3'd2,
        MD_DIV_SUB = 3'd3,
        MD_DONE    = 3'd4
    } md_state_e;

endpackage : alu_pkg

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL / DIVU / REMU sequencer. It owns no arithmetic
// datapath: every add, subtract and compare goes through the shared ALU
// (instantiated in the parent) via alu_a/alu_b/alu_op while busy is high.
// Multiply is shift-add (1 cycle/bit); divide is restoring (2 cycles/bit:
// compare with SLTU, then conditional subtract).
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       func,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int              CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);

    md_state_e        state_q, state_d;
    // acc_q: product accumulator (MUL) / partial remainder R (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;
    // qm_q: multiplier (MUL) / dividend-quotient Q (DIV)
    logic [WIDTH-1:0] qm_q, qm_d;
    // md_q: shifted multiplicand (MUL) / divisor D (DIV)
    logic [WIDTH-1:0] md_q, md_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       func_q, func_d;
    logic             ge_q, ge_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             in_ready_q, busy_q, res_valid_q;

    logic [CNT_W-1:0] cnt_inc_s;
    logic [WIDTH-1:0] rs_s;
    logic             ovf_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] quo_s;

    // Counter saturates so it can never wrap into a fresh iteration count.
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_W'(1));

    // Shifted remainder {ovf, Rs} = {R, Q[msb]}; ovf is the bit that falls
    // off the top and forces "R >= D" regardless of the 32-bit compare.
    assign ovf_s = acc_q[WIDTH-1];
    assign rs_s  = {acc_q[WIDTH-2:0], qm_q[WIDTH-1]};

    // Restore-or-subtract outcome of the current DIV_SUB cycle. In the ovf
    // case the modulo-2^32 subtraction still yields the true remainder.
    assign rem_s = ge_q ? alu_result : acc_q;
    assign quo_s = {qm_q[WIDTH-1:1], ge_q};

    // Next-state, datapath update and ALU drive for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        qm_d     = qm_q;
        md_d     = md_q;
        cnt_d    = cnt_q;
        func_d   = func_q;
        ge_d     = ge_q;
        result_d = result_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = ALU_ADD;

        case (state_q)
            MD_IDLE: begin
                if (in_valid) begin
                    func_d = func;
                    cnt_d  = '0;
                    acc_d  = '0;
                    case (func)
                        FUNC_MUL: begin
                            md_d    = op_a;
                            qm_d    = op_b;
                            state_d = MD_MUL;
                        end
                        FUNC_DIVU, FUNC_REMU: begin
                            qm_d = op_a;
                            md_d = op_b;
                            if (op_b == '0) begin
                                result_d = (func == FUNC_DIVU) ? '1 : op_a;
                                state_d  = MD_DONE;
                            end else begin
                                state_d  = MD_DIV_CMP;
                            end
                        end
                        default: begin
                            result_d = '0;
                            state_d  = MD_DONE;
                        end
                    endcase
                end else begin
                    state_d = MD_IDLE;
                end
            end

            MD_MUL: begin
                alu_op = ALU_ADD;
                alu_a  = acc_q;
                alu_b  = qm_q[0] ? md_q : '0;
                acc_d  = alu_result;
                md_d   = md_q << 1;
                qm_d   = qm_q >> 1;
                cnt_d  = cnt_inc_s;
                if (cnt_q == CNT_LAST) begin
                    result_d = alu_result;
                    state_d  = MD_DONE;
                end else begin
                    state_d  = MD_MUL;
                end
            end

            MD_DIV_CMP: begin
                alu_op  = ALU_SLTU;
                alu_a   = rs_s;
                alu_b   = md_q;
                acc_d   = rs_s;
                qm_d    = {qm_q[WIDTH-2:0], 1'b0};
                ge_d    = ovf_s | ~alu_result[0];
                state_d = MD_DIV_SUB;
            end

            MD_DIV_SUB: begin
                alu_op = ALU_SUB;
                alu_a  = acc_q;
                alu_b  = md_q;
                acc_d  = rem_s;
                qm_d   = quo_s;
                cnt_d  = cnt_inc_s;
                if (cnt_q == CNT_LAST) begin
                    result_d = (func_q == FUNC_DIVU) ? quo_s : rem_s;
                    state_d  = MD_DONE;
                end else begin
                    state_d  = MD_DIV_CMP;
                end
            end

            MD_DONE: begin
                if (res_ready) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = MD_DONE;
                end
            end

            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake flags; synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= MD_IDLE;
            acc_q       <= '0;
            qm_q        <= '0;
            md_q        <= '0;
            cnt_q       <= '0;
            func_q      <= FUNC_MUL;
            ge_q        <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            qm_q        <= qm_d;
            md_q        <= md_d;
            cnt_q       <= cnt_d;
            func_q      <= func_d;
            ge_q        <= ge_d;
            result_q    <= result_d;
            in_ready_q  <= (state_d == MD_IDLE);
            busy_q      <= (state_d != MD_IDLE);
            res_valid_q <= (state_d == MD_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign result    = result_q;

endmodule : muldiv_sequencer
